stream_downsize: RTL and testbench

- Wide-to-narrow stream converter; the inverse of stream_upsize.
- Accepts one wide beat of T_DATA_RATIO lanes with a per-lane keep mask and last flag, then emits the kept lanes one per transfer on a narrow stream, lane 0 first.
- Sits on the egress side of wide processing, returning packed wide beats to a byte/word-serial interface.

---
 rtl/stream_downsize.sv | 95 +++++++++
 tb/tb_stream_downsize.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsize.sv
// rtl/stream_downsize.sv - wide-to-narrow stream converter, emits kept lanes one per transfer
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   s_data_i       wide input lanes, lane 0 is first in time
//   s_keep_i       per-lane valid mask, bit i qualifies lane i
//   s_last_i       wide beat is last of packet
//   s_valid_i      wide beat valid
//   s_ready_o      block can accept a wide beat
//   m_data_o       narrow output word
//   m_last_o       final word of packet
//   m_valid_o      narrow word valid
//   m_ready_i      downstream accepts word
//   drop_o         one-cycle pulse after an all-zero-keep beat was accepted and discarded
module stream_downsize #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    drop_o
);

    localparam int IDX_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam logic [T_DATA_RATIO-1:0] MASK_ONE = {{(T_DATA_RATIO-1){1'b0}}, 1'b1};

    logic [T_DATA_WIDTH-1:0] buf_data [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem_mask;
    logic                    buf_last;

    logic [IDX_W-1:0]        low_idx;
    logic [T_DATA_RATIO-1:0] rem_mask_clr;
    logic                    mask_nonzero;
    logic                    mask_one_hot;
    logic                    in_xfer;
    logic                    out_xfer;

    // Lowest set lane: scanning from the top down lets the lowest hit win.
    always_comb begin
        low_idx = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (rem_mask[i]) begin
                low_idx = i[IDX_W-1:0];
            end
        end
    end

    // x & (x-1) drops the lowest set bit; a zero result on a nonzero mask
    // means exactly one lane remains.
    assign rem_mask_clr = rem_mask & (rem_mask - MASK_ONE);
    assign mask_nonzero = (rem_mask != '0);
    assign mask_one_hot = mask_nonzero && (rem_mask_clr == '0);

    // Accepting while the last lane leaves keeps back-to-back beats bubble-free.
    assign s_ready_o = !rst && (!mask_nonzero || (m_ready_i && mask_one_hot));
    assign m_valid_o = mask_nonzero;
    assign m_data_o  = mask_nonzero ? buf_data[low_idx] : '0;
    assign m_last_o  = buf_last && mask_one_hot;

    assign in_xfer  = s_valid_i && s_ready_o;
    assign out_xfer = m_valid_o && m_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_mask <= '0;
            buf_last <= 1'b0;
            drop_o   <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            drop_o <= in_xfer && (s_keep_i == '0);
            // A load only happens when the old mask is spent, so it overrides the clear.
            if (in_xfer) begin
                rem_mask <= s_keep_i;
                buf_last <= s_last_i;
                for (int i = 0; i < T_DATA_RATIO; i++) begin
                    buf_data[i] <= s_data_i[i];
                end
            end else if (out_xfer) begin
                rem_mask <= rem_mask_clr;
            end
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// tb/tb_stream_downsize.sv - directed table-driven bench for stream_downsize
module tb_stream_downsize;

    localparam int W = 8;
    localparam int R = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   s_data [R];
    logic [R-1:0]   s_keep;
    logic           s_last;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   m_data;
    logic           m_last;
    logic           m_valid;
    logic           m_ready;
    logic           drop;

    int total = 0;
    int bad   = 0;

    stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data),
        .s_keep_i  (s_keep),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .drop_o    (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [R-1:0]   keep;
        logic [W-1:0]   base;
        logic           last;
        int             n;
        logic [127:0]   exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_lanes(input logic [W-1:0] base);
        for (int i = 0; i < R; i++) s_data[i] = base + W'(i);
    endtask

    // Loads one beat with m_ready held high and checks every emitted word
    // arrives on consecutive cycles, followed by an idle output.
    task automatic run_beat(input logic [R-1:0] keep, input logic [W-1:0] base,
                            input logic last, input int n, input logic [127:0] exp);
        logic [127:0] e;
        e = exp;
        m_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready", s_ready, 1);
        set_lanes(base);
        s_keep  = keep;
        s_last  = last;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        chk("no_drop", drop, 0);
        for (int k = 0; k < n; k++) begin
            chk("word_valid", m_valid, 1);
            chk("word_data", m_data, e[k*8 +: 8]);
            chk("word_last", m_last, (last && k == n - 1) ? 1 : 0);
            @(negedge clk);
        end
        chk("after_idle", m_valid, 0);
    endtask

    logic [W-1:0] prev_data;
    logic         prev_last, prev_valid, prev_ready;
    int           sb_idx, last_cnt;

    initial begin
        vecs[0] = '{keep: 16'hFFFF, base: 8'h00, last: 1'b1, n: 16,
                    exp: 128'h0F0E0D0C0B0A09080706050403020100};
        vecs[1] = '{keep: 16'h8421, base: 8'h10, last: 1'b1, n: 4, exp: 128'h1F1A1510};
        vecs[2] = '{keep: 16'h8001, base: 8'h30, last: 1'b1, n: 2, exp: 128'h3F30};
        vecs[3] = '{keep: 16'h0001, base: 8'h50, last: 1'b1, n: 1, exp: 128'h50};
        vecs[4] = '{keep: 16'h0006, base: 8'h60, last: 1'b0, n: 2, exp: 128'h6261};

        rst = 1'b1; s_valid = 1'b0; s_keep = '0; s_last = 1'b0; m_ready = 1'b1;
        set_lanes(8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", s_ready, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_drop", drop, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", s_ready, 1);

        for (int v = 0; v < 5; v++) begin
            run_beat(vecs[v].keep, vecs[v].base, vecs[v].last, vecs[v].n, vecs[v].exp);
        end

        // Back-to-back full beats: second beat accepted as the first one's last word leaves.
        @(negedge clk);
        set_lanes(8'h00); s_keep = 16'hFFFF; s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("b2b_a_data", m_data, k);
            chk("b2b_a_last", m_last, (k == 15) ? 1 : 0);
            chk("b2b_a_ready", s_ready, (k == 15) ? 1 : 0);
            if (k == 15) begin
                set_lanes(8'h20);
                s_valid = 1'b1;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("b2b_b_valid", m_valid, 1);
            chk("b2b_b_data", m_data, 8'h20 + k);
            chk("b2b_b_last", m_last, (k == 15) ? 1 : 0);
            @(negedge clk);
        end
        chk("b2b_idle", m_valid, 0);

        // Backpressure with random ready and a scoreboard.
        set_lanes(8'h00); s_keep = 16'hFFFF; s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        sb_idx = 0; last_cnt = 0; prev_valid = 1'b0; prev_ready = 1'b1;
        prev_data = '0; prev_last = 1'b0;
        for (int c = 0; c < 200; c++) begin
            m_ready = ($urandom_range(0, 9) < 3);
            #1;
            if (prev_valid && !prev_ready) begin
                chk("bp_hold_valid", m_valid, 1);
                chk("bp_hold_data", m_data, prev_data);
                chk("bp_hold_last", m_last, prev_last);
            end
            if (m_valid) begin
                chk("bp_ready", s_ready, (m_ready && sb_idx == 15) ? 1 : 0);
                if (m_ready) begin
                    chk("bp_sb_data", m_data, sb_idx);
                    chk("bp_sb_last", m_last, (sb_idx == 15) ? 1 : 0);
                    if (m_last) last_cnt++;
                    sb_idx++;
                end
            end
            prev_valid = m_valid; prev_ready = m_ready;
            prev_data = m_data; prev_last = m_last;
            @(negedge clk);
        end
        chk("bp_count", sb_idx, 16);
        chk("bp_last_count", last_cnt, 1);
        chk("bp_idle", m_valid, 0);
        m_ready = 1'b1;

        // Zero keep beat.
        @(negedge clk);
        s_keep = 16'h0000; s_last = 1'b1; s_valid = 1'b1;
        chk("zk_ready_before", s_ready, 1);
        chk("zk_drop_before", drop, 0);
        @(negedge clk);
        s_valid = 1'b0;
        chk("zk_drop", drop, 1);
        chk("zk_valid", m_valid, 0);
        chk("zk_ready", s_ready, 1);
        @(negedge clk);
        chk("zk_drop_end", drop, 0);
        chk("zk_valid_end", m_valid, 0);
        chk("zk_ready_end", s_ready, 1);

        // Mid-beat reset after 5 words have transferred.
        set_lanes(8'h00); s_keep = 16'hFFFF; s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("mr_data", m_data, k);
            @(negedge clk);
        end
        chk("mr_word5", m_data, 5);
        rst = 1'b1;
        #1;
        chk("mr_ready_in_rst", s_ready, 0);
        @(negedge clk);
        chk("mr_valid", m_valid, 0);
        chk("mr_rst_data", m_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_ready_after", s_ready, 1);
        chk("mr_valid_after", m_valid, 0);
        run_beat(16'hFFFF, 8'h40, 1'b1, 16, 128'h4F4E4D4C4B4A49484746454443424140);

        // Single-lane streaming, one word per cycle.
        @(negedge clk);
        s_data[0] = 8'h00; s_keep = 16'h0001; s_last = 1'b0; s_valid = 1'b1;
        chk("sl_ready0", s_ready, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("sl_valid", m_valid, 1);
            chk("sl_data", m_data, k);
            chk("sl_last", m_last, 0);
            chk("sl_ready", s_ready, 1);
            if (k < 9) s_data[0] = W'(k + 1);
            else s_valid = 1'b0;
        end
        @(negedge clk);
        chk("sl_idle", m_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
